mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, wait-stated 16-bit memory between the CPU instruction-fetch port and the CPU data port.
- Turns the CPU's split instruction/data memory interface into a unified memory, giving a von Neumann build of the same CPU.
- Each port uses a req/ack handshake. Concurrent requests are granted 2-way round-robin.
- The memory access time is a parameter (WAIT).

Parameters:
- AW, 16, address width of both CPU ports and the memory port.
- DW, 16, data width.
- WAIT, 1, extra memory cycles per access beyond the first (legal 0..15; counter is 4 bits).

Ports:
- CK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_rdata  out  DW  fetched word; registered, valid from the i_ack cycle onward.
- i_ack  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data; registered, valid from the d_ack cycle onward.
- d_ack  out  1  one-cycle pulse: data access complete.
- m_en  out  1  memory access active.
- m_we  out  1  memory write strobe; only ever high while m_en is high.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; valid in the last ACCESS cycle.

Behaviour:

Reset:
- RST low asynchronously clears all outputs and registers to 0. State goes to IDLE and last_gnt goes to D, so I wins the first tie.

FSM states:
- IDLE:
  - Samples i_req and d_req.
  - Single requester: that requester is granted.
  - Both requesting: the port not equal to last_gnt is granted.
  - No request: state stays IDLE and m_en stays 0.
  - On a grant: latch addr, we (forced 0 for I) and wdata into m_* regs; set m_en=1, cnt=WAIT, last_gnt=granted; next state ACCESS.
- ACCESS:
  - m_en, m_we, m_addr and m_wdata are held stable.
  - While cnt != 0, decrement cnt.
  - When cnt == 0:
    - On a read, capture m_rdata into the granted port's rdata register.
    - Clear m_en and m_we; set the granted port's ack; next state RESP.
- RESP:
  - Exactly one ack is high for this one cycle. Requests are ignored in this cycle.
  - Clear ack; next state IDLE.

Timing:
- Latency from req sampled in IDLE to ack is WAIT+2 cycles.
- m_en is high for WAIT+1 cycles per access.
- Throughput is one access per WAIT+3 cycles.

Handshake rules:
- The requester must drop req at the edge ending the ack cycle. A req still high in IDLE is treated as a new request.
- Dropping req before ack does not abort: the access completes and ack still pulses.
- A write leaves d_rdata unchanged.
- i_rdata and d_rdata hold their values until the next read completes on the same port.

Boundary conditions:
- No starvation: under continuous requests on both ports, grants alternate strictly I, D, I, D.
- Requests arriving during ACCESS or RESP wait until the next IDLE.
- Reset mid-access: m_en and m_we drop immediately, no ack is issued, and the access is lost. After release, a still-asserted request is re-arbitrated from IDLE with I priority.
- WAIT=0: ACCESS lasts exactly one cycle.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding localparams S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2.
  - Port ids P_I=1'b0, P_D=1'b1.
  - Counter width CW=4.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req_i, req_d, last_gnt.
  - Outputs: gnt_valid, gnt_id.
  - last_gnt is owned by mem_arbiter.

Test Plan:
- Reset/idle: hold RST=0 with i_req=d_req=1 -> every output is 0. Release with no requests for 10 cycles -> m_en stays 0 and no ack pulses.
- Single fetch, WAIT=1: i_req, i_addr=16'h0007, m_rdata=16'h0112 -> m_en=1, m_addr=16'h0007, m_we=0 on cycles 1-2; i_ack on cycle 3 only; i_rdata=16'h0112; d_ack never pulses.
- Data write, WAIT=1: d_req, d_we=1, d_addr=16'h0005, d_wdata=16'hBEEF -> m_we=1, m_wdata=16'hBEEF for 2 cycles; d_ack on cycle 3; d_rdata unchanged from its prior value.
- Contention: i_req and d_req both held continuously after reset, each dropped and re-raised on its ack -> grant order I, D, I, D; acks 4 cycles apart (WAIT=1).
- Latency sweep: WAIT=0 -> ack 2 cycles after req; WAIT=15 -> ack 17 cycles after req, m_en high exactly 16 cycles.
- Reset mid-access: RST low in the 2nd ACCESS cycle of a d write -> m_en and m_we drop without waiting for the clock and no d_ack. After release, with both requests pending, I is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Port ids double as the round-robin history value.
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;

  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_ACCESS = S_ACCESS,
    ST_RESP   = S_RESP
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU split-port bundle plus the shared memory port.
// The slave view is the arbiter; the master view is the CPU and memory side.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker; on a tie the port that did not win last time is chosen.
// No state here: the caller owns and updates last_gnt.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_id    = P_I;
    if (req_i && req_d) begin
      gnt_id = ~last_gnt;
    end else if (req_d) begin
      gnt_id = P_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one wait-stated single-port memory between the CPU fetch and data ports.
// Ack arrives WAIT+2 cycles after a request is taken in IDLE; one access per WAIT+3 cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input  logic         CK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_gnt_q;
  logic          gnt_q;
  logic          m_en_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_ack_q;
  logic          d_ack_q;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_rr (
    .req_i     (bus.i_req),
    .req_d     (bus.d_req),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= P_D;  // fetch wins the first tie after reset
      gnt_q      <= P_I;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt_q      <= gnt_id;
            last_gnt_q <= gnt_id;
            m_en_q     <= 1'b1;
            cnt_q      <= CW'(WAIT);
            state_q    <= ST_ACCESS;
            if (gnt_id == P_I) begin
              m_we_q    <= 1'b0;
              m_addr_q  <= bus.i_addr;
              m_wdata_q <= '0;
            end else begin
              m_we_q    <= bus.d_we;
              m_addr_q  <= bus.d_addr;
              m_wdata_q <= bus.d_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // m_rdata is only guaranteed valid in this final access cycle
            if (!m_we_q) begin
              if (gnt_q == P_I) i_rdata_q <= bus.m_rdata;
              else              d_rdata_q <= bus.m_rdata;
            end
            m_en_q  <= 1'b0;
            m_we_q  <= 1'b0;
            i_ack_q <= (gnt_q == P_I);
            d_ack_q <= (gnt_q == P_D);
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_ack   = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on WAIT=1/0/15 instances plus a
// randomized run checked against a transaction-timeline model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int W1 = 1;

  logic CK  = 1'b0;
  logic RST = 1'b0;
  always #5 CK = ~CK;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter_if #(.AW(16), .DW(16)) bus1 ();
  mem_arbiter_if #(.AW(16), .DW(16)) bus0 ();
  mem_arbiter_if #(.AW(16), .DW(16)) bus15 ();

  mem_arbiter #(.AW(16), .DW(16), .WAIT(1))  u_dut (.CK(CK), .RST(RST), .bus(bus1));
  mem_arbiter #(.AW(16), .DW(16), .WAIT(0))  u_w0  (.CK(CK), .RST(RST), .bus(bus0));
  mem_arbiter #(.AW(16), .DW(16), .WAIT(15)) u_w15 (.CK(CK), .RST(RST), .bus(bus15));

  // Memory device behind the WAIT=1 instance (64 words mirrored across the space)
  logic [15:0] mem [64];
  assign bus1.m_rdata = mem[bus1.m_addr[5:0]];
  always @(posedge CK) begin
    if (bus1.m_en && bus1.m_we) mem[bus1.m_addr[5:0]] = bus1.m_wdata;
  end
  assign bus0.m_rdata  = 16'h0A0A;
  assign bus15.m_rdata = 16'h0F0F;

  task automatic idle_inputs();
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus0.i_req = 0; bus0.i_addr = '0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus15.i_req = 0; bus15.i_addr = '0; bus15.d_req = 0; bus15.d_we = 0; bus15.d_addr = '0; bus15.d_wdata = '0;
  endtask

  // Leaves the bench at a negedge just after release; the next posedge is cycle 1.
  task automatic do_reset();
    @(negedge CK);
    RST = 1'b0;
    idle_inputs();
    repeat (2) @(negedge CK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus1.i_req = 1; bus1.d_req = 1; bus1.i_addr = 16'h1234; bus1.d_we = 1; bus1.d_addr = 16'h4321; bus1.d_wdata = 16'hFFFF;
    repeat (3) @(negedge CK);
    n_tests++;
    if ({bus1.m_en, bus1.m_we, bus1.i_ack, bus1.d_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: en/we/iack/dack=%b want 0000", {bus1.m_en, bus1.m_we, bus1.i_ack, bus1.d_ack});
    end
    n_tests++;
    if ({bus1.m_addr, bus1.m_wdata, bus1.i_rdata, bus1.d_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h ird=%h drd=%h want all 0", bus1.m_addr, bus1.m_wdata, bus1.i_rdata, bus1.d_rdata);
    end
    idle_inputs();
    RST = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CK);
      n_tests++;
      if ({bus1.m_en, bus1.i_ack, bus1.d_ack} !== 3'b000) begin
        n_fail++; $display("FAIL idle_quiet c=%0d: en/iack/dack=%b want 000", c, {bus1.m_en, bus1.i_ack, bus1.d_ack});
      end
    end
  endtask

  task automatic test_fetch();
    logic exp_en, exp_ack;
    do_reset();
    mem[7] = 16'h0112;
    bus1.i_addr = 16'h0007; bus1.i_req = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CK);
      exp_en  = (c == 1 || c == 2);
      exp_ack = (c == 3);
      n_tests++;
      if (bus1.m_en !== exp_en || (exp_en && (bus1.m_addr !== 16'h0007 || bus1.m_we !== 1'b0))) begin
        n_fail++; $display("FAIL fetch_bus c=%0d: en=%b addr=%h we=%b want en=%b addr=0007 we=0", c, bus1.m_en, bus1.m_addr, bus1.m_we, exp_en);
      end
      n_tests++;
      if (bus1.i_ack !== exp_ack || bus1.d_ack !== 1'b0) begin
        n_fail++; $display("FAIL fetch_ack c=%0d: iack=%b dack=%b want %b 0", c, bus1.i_ack, bus1.d_ack, exp_ack);
      end
      if (c == 3) begin
        n_tests++;
        if (bus1.i_rdata !== 16'h0112) begin
          n_fail++; $display("FAIL fetch_rdata: got %h want 0112", bus1.i_rdata);
        end
        bus1.i_req = 0;
      end
    end
  endtask

  task automatic test_write();
    logic exp_en, exp_ack;
    do_reset();
    mem[5] = 16'h5555;
    bus1.d_addr = 16'h0005; bus1.d_we = 1; bus1.d_wdata = 16'hBEEF; bus1.d_req = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CK);
      exp_en  = (c == 1 || c == 2);
      exp_ack = (c == 3);
      n_tests++;
      if (bus1.m_en !== exp_en || bus1.m_we !== exp_en ||
          (exp_en && (bus1.m_wdata !== 16'hBEEF || bus1.m_addr !== 16'h0005))) begin
        n_fail++; $display("FAIL write_bus c=%0d: en=%b we=%b addr=%h wdata=%h want en=we=%b 0005 BEEF", c, bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wdata, exp_en);
      end
      n_tests++;
      if (bus1.d_ack !== exp_ack || bus1.i_ack !== 1'b0) begin
        n_fail++; $display("FAIL write_ack c=%0d: dack=%b iack=%b want %b 0", c, bus1.d_ack, bus1.i_ack, exp_ack);
      end
      if (c == 3) begin
        n_tests++;
        if (bus1.d_rdata !== 16'h0000) begin
          n_fail++; $display("FAIL write_drdata: got %h want 0000", bus1.d_rdata);
        end
        bus1.d_req = 0;
      end
    end
    n_tests++;
    if (mem[5] !== 16'hBEEF) begin
      n_fail++; $display("FAIL write_mem: got %h want BEEF", mem[5]);
    end
  endtask

  task automatic test_contention();
    logic exp_i, exp_d;
    do_reset();
    bus1.i_addr = 16'h0011; bus1.d_addr = 16'h0022; bus1.d_we = 0;
    bus1.i_req = 1; bus1.d_req = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CK);
      // grants every 4 cycles starting with I; ack lands 2 cycles after each grant
      exp_i = (c >= 3) && ((c - 3) % 4 == 0) && (((c - 3) / 4) % 2 == 0);
      exp_d = (c >= 3) && ((c - 3) % 4 == 0) && (((c - 3) / 4) % 2 == 1);
      n_tests++;
      if (bus1.i_ack !== exp_i || bus1.d_ack !== exp_d) begin
        n_fail++; $display("FAIL contention c=%0d: iack=%b dack=%b want %b %b", c, bus1.i_ack, bus1.d_ack, exp_i, exp_d);
      end
    end
    idle_inputs();
    repeat (6) @(negedge CK);
  endtask

  task automatic test_latency();
    int ack0 = -1, ack15 = -1, en0 = 0, en15 = 0;
    do_reset();
    bus0.i_addr = 16'h0003;  bus0.i_req = 1;
    bus15.i_addr = 16'h0004; bus15.i_req = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CK);
      if (bus0.m_en === 1'b1) en0++;
      if (bus15.m_en === 1'b1) en15++;
      if (bus0.i_ack === 1'b1 && ack0 < 0) begin ack0 = c; bus0.i_req = 0; end
      if (bus15.i_ack === 1'b1 && ack15 < 0) begin ack15 = c; bus15.i_req = 0; end
    end
    n_tests++;
    if (ack0 != 2 || en0 != 1) begin
      n_fail++; $display("FAIL lat_w0: ack at %0d en cycles %0d want 2 and 1", ack0, en0);
    end
    n_tests++;
    if (ack15 != 17 || en15 != 16) begin
      n_fail++; $display("FAIL lat_w15: ack at %0d en cycles %0d want 17 and 16", ack15, en15);
    end
    n_tests++;
    if (bus0.i_rdata !== 16'h0A0A || bus15.i_rdata !== 16'h0F0F) begin
      n_fail++; $display("FAIL lat_rdata: w0=%h w15=%h want 0A0A 0F0F", bus0.i_rdata, bus15.i_rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus1.d_addr = 16'h0003; bus1.d_we = 1; bus1.d_wdata = 16'hCAFE; bus1.d_req = 1;
    @(negedge CK);
    @(posedge CK);
    #2;
    n_tests++;
    if (bus1.m_en !== 1'b1 || bus1.m_we !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: en=%b we=%b want 1 1", bus1.m_en, bus1.m_we);
    end
    RST = 1'b0;
    bus1.i_addr = 16'h0009; bus1.i_req = 1;
    #1;
    n_tests++;
    if (bus1.m_en !== 1'b0 || bus1.m_we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: en=%b we=%b want 0 0", bus1.m_en, bus1.m_we);
    end
    repeat (2) begin
      @(negedge CK);
      n_tests++;
      if (bus1.d_ack !== 1'b0 || bus1.m_en !== 1'b0) begin
        n_fail++; $display("FAIL midrst_hold: dack=%b en=%b want 0 0", bus1.d_ack, bus1.m_en);
      end
    end
    RST = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CK);
      if (c < 3) begin
        n_tests++;
        if (bus1.m_en !== 1'b1 || bus1.m_addr !== 16'h0009 || bus1.m_we !== 1'b0) begin
          n_fail++; $display("FAIL midrst_regrant c=%0d: en=%b addr=%h we=%b want 1 0009 0", c, bus1.m_en, bus1.m_addr, bus1.m_we);
        end
      end else begin
        n_tests++;
        if (bus1.i_ack !== 1'b1 || bus1.d_ack !== 1'b0) begin
          n_fail++; $display("FAIL midrst_ack: iack=%b dack=%b want 1 0", bus1.i_ack, bus1.d_ack);
        end
      end
    end
    idle_inputs();
    repeat (8) @(negedge CK);
  endtask

  // Model: an access granted at edge g runs m_en over cycles g..g+W1, acks at g+W1+1,
  // and the arbiter next looks at requests at edge g+W1+3.
  task automatic test_random();
    logic [15:0] ref_mem [64];
    logic [15:0] exp_ir, exp_dr, g_addr, g_wd;
    logic        g_we, exp_en, ack_now;
    bit          act, g_port, lp;
    int          free_e, g_e;
    do_reset();
    for (int a = 0; a < 64; a++) begin
      mem[a]     = 16'(a * 257) ^ 16'h5A00;
      ref_mem[a] = 16'(a * 257) ^ 16'h5A00;
    end
    exp_ir = '0; exp_dr = '0; act = 0; lp = 1'b1; free_e = 0; g_e = 0;
    g_port = 0; g_we = 0; g_addr = '0; g_wd = '0;
    for (int c = 0; c < 600; c++) begin
      exp_en  = act && (c >= g_e) && (c <= g_e + W1);
      ack_now = act && (c == g_e + W1 + 1);
      if (ack_now) begin
        if (g_we) ref_mem[g_addr[5:0]] = g_wd;
        else if (g_port) exp_dr = ref_mem[g_addr[5:0]];
        else exp_ir = ref_mem[g_addr[5:0]];
      end
      n_tests++;
      if (bus1.m_en !== exp_en || bus1.i_ack !== (ack_now && !g_port) || bus1.d_ack !== (ack_now && g_port)) begin
        n_fail++; $display("FAIL rand_ctrl c=%0d: en=%b iack=%b dack=%b want en=%b ack=%b port=%0d", c, bus1.m_en, bus1.i_ack, bus1.d_ack, exp_en, ack_now, g_port);
      end
      if (exp_en) begin
        n_tests++;
        if (bus1.m_addr !== g_addr || bus1.m_we !== g_we || (g_we && bus1.m_wdata !== g_wd)) begin
          n_fail++; $display("FAIL rand_bus c=%0d: addr=%h we=%b wd=%h want %h %b %h", c, bus1.m_addr, bus1.m_we, bus1.m_wdata, g_addr, g_we, g_wd);
        end
      end
      n_tests++;
      if (bus1.i_rdata !== exp_ir || bus1.d_rdata !== exp_dr) begin
        n_fail++; $display("FAIL rand_rdata c=%0d: ird=%h drd=%h want %h %h", c, bus1.i_rdata, bus1.d_rdata, exp_ir, exp_dr);
      end
      if (ack_now) begin
        if (g_port) bus1.d_req = 0; else bus1.i_req = 0;
      end
      if (!bus1.i_req && $urandom_range(0, 2) == 0) begin
        bus1.i_req = 1; bus1.i_addr = 16'($urandom_range(0, 63));
      end
      if (!bus1.d_req && $urandom_range(0, 2) == 0) begin
        bus1.d_req = 1; bus1.d_we = 1'($urandom_range(0, 1));
        bus1.d_addr = 16'($urandom_range(0, 63)); bus1.d_wdata = 16'($urandom);
      end
      if (c + 1 >= free_e && (bus1.i_req || bus1.d_req)) begin
        g_port = (bus1.i_req && bus1.d_req) ? !lp : bus1.d_req;
        lp     = g_port;
        act    = 1;
        g_e    = c + 1;
        free_e = c + 1 + W1 + 3;
        g_we   = g_port ? bus1.d_we : 1'b0;
        g_addr = g_port ? bus1.d_addr : bus1.i_addr;
        g_wd   = bus1.d_wdata;
      end
      @(negedge CK);
    end
    idle_inputs();
    repeat (6) @(negedge CK);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_write();
    test_contention();
    test_latency();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
